// File: rtl/vfd_prescaler_pkg.sv
// Shared helpers for vfd_prescaler: ratio rounding and counter sizing.
package vfd_prescaler_pkg;

  function automatic int unsigned calc_ratio(input int unsigned f_in, input int unsigned f_out);
    if (f_out == 0) return 0;
    return (f_in + f_out / 2) / f_out;
  endfunction

  function automatic int unsigned calc_width(input int unsigned n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/vfd_prescaler.sv
// Integer clock prescaler: registered ~50% duty o_clk at f_clkout from clk at f_clkin.
// Define VFD_PRESCALER_TICK_EN to add the one-cycle o_tick pulse on each o_clk rise.
module vfd_prescaler
  import vfd_prescaler_pkg::*;
#(
  parameter int unsigned f_clkin  = 12_000,
  parameter int unsigned f_clkout = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef VFD_PRESCALER_TICK_EN
  output logic o_tick,
`endif
  output logic o_clk
);

  localparam int unsigned N  = calc_ratio(f_clkin, f_clkout);
  localparam int unsigned LO = N / 2;
  localparam int unsigned HI = N - LO;
  localparam int unsigned W  = calc_width(N);

  localparam logic [W-1:0] CNT_MAX = W'(N - 1);
  localparam logic [W-1:0] LO_V    = W'(LO);

  if (f_clkin == 0 || f_clkout == 0) begin : g_bad_freq
    $fatal(1, "vfd_prescaler: f_clkin and f_clkout must both be > 0");
  end else if (N < 2 || HI < LO) begin : g_bad_ratio
    $fatal(1, "vfd_prescaler: f_clkout too high, ratio must be at least 2");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         o_clk_q, o_clk_d;

  // Phase is decided from the next count so o_clk lines up with the counter wrap.
  always_comb begin
    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    o_clk_d = (cnt_d >= LO_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      o_clk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      o_clk_q <= o_clk_d;
    end
  end

  assign o_clk = o_clk_q;

`ifdef VFD_PRESCALER_TICK_EN
  logic o_tick_q, o_tick_d;

  always_comb begin
    o_tick_d = (cnt_d == LO_V);
  end

  always_ff @(posedge clk) begin
    if (rst) o_tick_q <= 1'b0;
    else     o_tick_q <= o_tick_d;
  end

  assign o_tick = o_tick_q;
`endif

endmodule

// File: tb/tb_vfd_prescaler.sv
// Self-checking bench for vfd_prescaler: four parameter sets against an arithmetic phase model.
module tb_vfd_prescaler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_a, o_b, o_c, o_d;
`ifdef VFD_PRESCALER_TICK_EN
  logic t_a, t_b, t_c, t_d;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vfd_prescaler u_a (
    .clk(clk), .rst(rst),
`ifdef VFD_PRESCALER_TICK_EN
    .o_tick(t_a),
`endif
    .o_clk(o_a));

  vfd_prescaler #(.f_clkin(7), .f_clkout(1)) u_b (
    .clk(clk), .rst(rst),
`ifdef VFD_PRESCALER_TICK_EN
    .o_tick(t_b),
`endif
    .o_clk(o_b));

  vfd_prescaler #(.f_clkin(2), .f_clkout(1)) u_c (
    .clk(clk), .rst(rst),
`ifdef VFD_PRESCALER_TICK_EN
    .o_tick(t_c),
`endif
    .o_clk(o_c));

  vfd_prescaler #(.f_clkin(10), .f_clkout(3)) u_d (
    .clk(clk), .rst(rst),
`ifdef VFD_PRESCALER_TICK_EN
    .o_tick(t_d),
`endif
    .o_clk(o_d));

  // Ratios written out by hand: 12000/2, 7/1, 2/1, and 10/3 rounded to 3.
  localparam int NA = 6000;
  localparam int NB = 7;
  localparam int NC = 2;
  localparam int ND = 3;

  task automatic chk(input string name, input int act, input int exp, input int edge_k);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d since reset release)", name, act, exp, edge_k);
    end
  endtask

  // After k non-reset edges the position in the period is k mod N; high once it reaches N/2.
  function automatic int exp_clk(input int k, input int n);
    return ((k % n) >= (n / 2)) ? 1 : 0;
  endfunction

  function automatic int exp_tick(input int k, input int n);
    return (k > 0 && (k % n) == (n / 2)) ? 1 : 0;
  endfunction

  int  k = 0;
  int  rise_k = -1;
  int  prev_a = 0;
  bit  rst_s;

  always @(posedge clk) begin
    rst_s = rst;
    #1;
    if (rst_s) k = 0;
    else       k++;

    chk("clk_a", int'(o_a), rst_s ? 0 : exp_clk(k, NA), k);
    chk("clk_b", int'(o_b), rst_s ? 0 : exp_clk(k, NB), k);
    chk("clk_c", int'(o_c), rst_s ? 0 : exp_clk(k, NC), k);
    chk("clk_d", int'(o_d), rst_s ? 0 : exp_clk(k, ND), k);
`ifdef VFD_PRESCALER_TICK_EN
    chk("tick_a", int'(t_a), rst_s ? 0 : exp_tick(k, NA), k);
    chk("tick_b", int'(t_b), rst_s ? 0 : exp_tick(k, NB), k);
    chk("tick_c", int'(t_c), rst_s ? 0 : exp_tick(k, NC), k);
    chk("tick_d", int'(t_d), rst_s ? 0 : exp_tick(k, ND), k);
`endif

    // Literal anchors so the model itself is pinned.
    if (!rst_s) begin
      if (k == 2999) chk("a_low_before_rise", int'(o_a), 0, k);
      if (k == 3000) chk("a_first_rise",      int'(o_a), 1, k);
      if (k == 6000) chk("a_fall_at_n",       int'(o_a), 0, k);
      if (k == 2)    chk("b_low_edge2",       int'(o_b), 0, k);
      if (k == 3)    chk("b_rise_edge3",      int'(o_b), 1, k);
      if (k == 6)    chk("b_high_edge6",      int'(o_b), 1, k);
      if (k == 7)    chk("b_fall_edge7",      int'(o_b), 0, k);
      if (k == 1)    chk("c_high_edge1",      int'(o_c), 1, k);
      if (k == 2)    chk("c_low_edge2",       int'(o_c), 0, k);
      if (k == 1)    chk("d_rise_edge1",      int'(o_d), 1, k);
      if (k == 3)    chk("d_fall_edge3",      int'(o_d), 0, k);
      if (k == 4)    chk("d_rise_edge4",      int'(o_d), 1, k);
    end else begin
      chk("a_low_in_reset", int'(o_a), 0, k);
    end

    // Edge-interval tracking on the default instance.
    if (rst_s) begin
      rise_k = -1;
    end else if (prev_a == 0 && o_a == 1'b1) begin
      if (rise_k < 0) chk("a_rise_after_release", k, 3000, k);
      else            chk("a_rise_interval", k - rise_k, NA, k);
      rise_k = k;
    end else if (prev_a == 1 && o_a == 1'b0 && rise_k >= 0) begin
      chk("a_high_time", k - rise_k, 3000, k);
    end
    prev_a = int'(o_a);
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    cycles(20);
    rst = 1'b0;
    cycles(4499);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(13000);
    for (int r = 0; r < 6; r++) begin
      cycles(int'($urandom_range(50, 3500)));
      rst = 1'b1;
      cycles(int'($urandom_range(1, 4)));
      rst = 1'b0;
    end
    cycles(13000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vfd_prescaler.md
Name: vfd_prescaler

Overview:
- Parameterised integer clock prescaler.
- Derives a slow, near-50 %-duty square wave (o_clk) from the system clock.
- Ratio is set by the nominal input and output frequencies, in Hz.
- Used wherever a slow periodic enable or clock-like signal is needed (LED blink, slow polling, and similar); the output is fabric logic, not a clock-tree clock.

Parameters:
- f_clkin, 12_000, nominal frequency of clk in Hz (integer > 0).
- f_clkout, 2, requested output frequency in Hz (integer > 0).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- o_clk  output  1  divided square wave, registered.

Behaviour:
- Derived constants, computed at elaboration:
  - N = (f_clkin + f_clkout/2) / f_clkout, the integer ratio rounded to nearest.
  - LO = N/2, rounded down.
  - HI = N − LO.
  - Counter width W = max(1, $clog2(N)).
- Elaboration checks, each stopping elaboration with a message on violation:
  - f_clkin > 0 and f_clkout > 0.
  - N ≥ 2; otherwise f_clkout is too high.
- State:
  - W-bit counter cnt, range 0..N−1.
  - 1-bit register o_clk.
  - No other state.
- Reset (rst=1 at a rising edge): cnt ← 0, o_clk ← 0. Reset has priority over everything else; asserting it mid-period restarts the waveform from the low phase.
- Run (rst=0): cnt increments by 1 each edge and wraps from N−1 to 0.
- o_clk is registered from the next count value:
  - o_clk ← 1 when the next cnt is in LO..N−1 (high phase).
  - o_clk ← 0 when the next cnt is in 0..LO−1 (low phase).
- Cycle-level timing, counting edge 1 as the first rising edge with rst=0:
  - o_clk rises at edge LO.
  - o_clk falls at edge N.
  - o_clk rises again at edge N+LO, and so on.
  - Period is exactly N clk cycles: low for LO cycles, high for HI cycles.
  - For odd N the high phase is one cycle longer.
- Glitch-free: o_clk changes only directly from a flop, at most once per clk cycle.
- Default parameters: N=6000, LO=HI=3000. At a 10 ns clk the period is 60 000 ns and the first rise comes 30 000 ns after the first edge following reset release.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro VFD_PRESCALER_TICK_EN.
- When defined:
  - Adds output o_tick (1 bit, registered).
  - o_tick is high for exactly one clk cycle, on the same edge where o_clk rises (next cnt == LO).
  - o_tick is 0 in and directly after reset.
- When undefined:
  - Port o_tick and its logic are absent.
  - o_clk behaviour is identical in both builds.

Decomposition:
- Package vfd_prescaler_pkg holds:
  - function calc_ratio(f_in, f_out), returning N with rounding;
  - function calc_width(n), returning max(1, $clog2(n)).
- Module-local localparams N, LO, HI, W use these functions.
- No sub-module; the counter and phase compare are small enough to live in vfd_prescaler.

Test Plan:
- Default parameters, 10 ns clk, rst high for 20 cycles then low, run 500 000 cycles:
  - o_clk first rises at edge 3000;
  - every later rising-to-rising interval is 6000 cycles (60 000 ns);
  - high time is 3000 cycles;
  - about 83 periods are seen.
- f_clkin=7, f_clkout=1 (N=7):
  - o_clk is low for 3 cycles and high for 4;
  - period is 7 cycles, repeated for 10 periods.
- f_clkin=2, f_clkout=1 (N=2): o_clk toggles on every edge (0,1,0,1…), starting 0 at reset and 1 at edge 1.
- Rounding with f_clkin=10, f_clkout=3: N=3 and the measured period is 3 cycles.
- Reset mid-operation: assert rst for one cycle at edge 4500 of the default run:
  - o_clk is 0 on the next edge;
  - the next rise comes exactly 3000 edges after rst deasserts.
- With VFD_PRESCALER_TICK_EN, default parameters:
  - o_tick pulses for 1 cycle coincident with each o_clk rise;
  - pulses are 6000 cycles apart;
  - o_tick is never high during reset.
